bcd_mux_display: RTL
====================

Name: bcd_mux_display

Overview:
- Parametrised successor to the switch-to-decimal display path.
- Converts an unsigned BIN_W-bit value to DIGITS BCD digits with a sequential double-dabble, one bit per cycle.
- Drives a multiplexed common-anode 7-segment display with leading-zero blanking and overflow indication.
- Sits between a register or switch source and the board display pins. The displayed value changes atomically, only when a conversion completes.

Parameters:
- BIN_W, 14, width of the binary input. Legal range is 4..32.
- DIGITS, 4, number of displayed digits and BCD digits. Legal range is 1..8.
- REFRESH_DIV, 50000, clk cycles each digit stays selected. Must be at least 2.
- BLANK_LZ, 1, selects leading-zero handling. 1 blanks leading zeros; 0 shows all digits.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- bin, input, BIN_W, unsigned value to display. Sampled on an accepted load.
- load, input, 1, start-conversion request. Single-cycle pulse or level.
- busy, output, 1, high while a conversion is in progress.
- overflow, output, 1, high while the displayed value exceeds 10^DIGITS-1.
- seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
- an, output, DIGITS, digit enables, active-low, one-hot-low.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high on rst; all state clears immediately on assertion.
- Reset values:
  - busy=0, overflow=0, seg=7'b1111111, an=all ones.
  - Display register holds 0. digit_sel=0, refresh counter=0, FSM in IDLE.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: when load=1, capture bin into the shift register with the BCD part cleared, capture over=(bin > 10^DIGITS-1), set bit counter=BIN_W-1, go to SHIFT. busy goes to 1 on the next cycle.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift left by 1. When bit counter=0, go to DONE; otherwise decrement.
  - DONE: copy the BCD nibbles into the display register and over into overflow, clear busy, go to IDLE.
- Latency and throughput:
  - BIN_W+2 cycles from load sampled to the display register updating; busy is high for BIN_W+1 cycles.
  - load while busy=1 is ignored, with no queueing.
  - load asserted in the cycle busy falls (IDLE re-entered) is accepted. Back-to-back conversions therefore run every BIN_W+2 cycles.
- Arithmetic:
  - The BCD field is 4*DIGITS bits; bits shifted out above it are discarded.
  - overflow is decided only by the comparison against the constant MAX_VAL=10^DIGITS-1, computed at elaboration with width BIN_W+1.
- Refresh:
  - The counter runs 0..REFRESH_DIV-1 continuously, independent of conversion.
  - On terminal count the counter returns to 0 and digit_sel advances, wrapping from DIGITS-1 to 0.
  - The counter and digit_sel are not reset by load.
- Output stage (seg/an registered, one cycle after digit_sel/display change):
  - an drives digit_sel low; all other bits are high.
  - If overflow=1: seg=7'b0111111 (dash) on every digit.
  - Else if BLANK_LZ=1 and the digit index is above the most significant nonzero digit, and the index is not 0: seg=7'b1111111 and an=all ones. Digit 0 always shows, so value 0 displays "0".
  - Else seg is the decoded nibble. Nibbles above 9 cannot occur; if one did, it would decode to blank.
- Reset mid-conversion: abort, discard the partial result, and return to reset values. The display shows "0" from the second cycle after rst deasserts.
- Simultaneous events:
  - A refresh tick together with a display update: the output stage uses the new display value and the new digit_sel together.
  - rst dominates everything.

Decomposition:
- Package bcd_disp_pkg:
  - SEG_W=7 and segment constants SEG_BLANK=7'b1111111, SEG_DASH=7'b0111111, SEG_0..SEG_9.
  - Function bcd_to_seg(nibble).
  - FSM state typedef {IDLE,SHIFT,DONE}.
  - Elaboration function pow10(n).
- Sub-module bcd_dd_seq:
  - Contains the iterative double-dabble FSM.
  - Ports: clk, rst, start, bin, busy, done pulse, bcd[4*DIGITS], over.
- The top level holds the display register, refresh counter, blanking logic and output registers.

Test Plan (BIN_W=14, DIGITS=4, REFRESH_DIV=4, BLANK_LZ=1):
- Reset: pulse rst, no load -> busy=0, overflow=0; after rst falls, only an=1110 with seg=1000000 ("0") appears; slots 1-3 give an=1111, seg=1111111.
- load bin=1023: busy high exactly 15 cycles, display updates at cycle 16. Over one refresh cycle: an=1110/seg=0110000, an=1101/seg=0100100, an=1011/seg=1000000, an=0111/seg=1111001.
- load bin=7 -> digit0 seg=1111000; digits 1-3 blanked (an=1111). Repeat with BLANK_LZ=0 -> digits 1-3 show seg=1000000.
- load bin=12000 -> overflow=1, every digit slot shows seg=0111111. Then load bin=9999 -> overflow=0, all digits seg=0010000.
- Ignored load: load bin=42, then load bin=500 three cycles later while busy -> result displays 42; busy does not re-extend.
- Reset mid-conversion: load bin=8888, assert rst at cycle 5 -> busy=0 immediately; after release, display shows "0", not 8888.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types, segment encodings and elaboration helpers for the
// multiplexed BCD 7-segment display path.
package bcd_disp_pkg;

    localparam int SEG_W = 7;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } dd_state_t;

    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_dd_seq.sv
// Iterative double-dabble converter: one binary bit per clock, with an
// overflow flag decided at load time against 10^DIGITS-1.
module bcd_dd_seq
    import bcd_disp_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  over
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    // Values too large for BIN_W+1 bits saturate, which can never be exceeded
    localparam longint unsigned MAX_FULL = pow10(DIGITS) - 1;
    localparam logic [BIN_W:0]  MAX_VAL  =
        (MAX_FULL >= (64'd1 << (BIN_W + 1))) ? '1 : MAX_FULL[BIN_W:0];

    dd_state_t         state, state_nx;
    logic [SR_W-1:0]   sr, sr_nx, adj;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              over_q, over_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            over_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values
            state  <= state_nx;
            sr     <= sr_nx;
            cnt    <= cnt_nx;
            over_q <= over_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        over_nx  = over_q;
        adj      = sr;
        case (state)
            IDLE: begin
                if (start) begin
                    sr_nx    = {{BCD_W{1'b0}}, bin};
                    over_nx  = ({1'b0, bin} > MAX_VAL);
                    cnt_nx   = CNT_W'(BIN_W - 1);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                for (int d = 0; d < DIGITS; d++) begin
                    if (adj[BIN_W + 4*d +: 4] >= 4'd5) begin
                        adj[BIN_W + 4*d +: 4] = adj[BIN_W + 4*d +: 4] + 4'd3;
                    end
                end
                // The top bit falls off: BCD bits above 4*DIGITS are discarded
                sr_nx = adj << 1;
                if (cnt == '0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = sr[SR_W-1 -: BCD_W];
    assign over = over_q;

endmodule

// File: rtl/bcd_mux_display.sv
// Binary-to-decimal multiplexed common-anode display: holds the last
// converted value, scans digits and applies blanking/overflow rules.
module bcd_mux_display
    import bcd_disp_pkg::*;
#(
    parameter int BIN_W       = 14,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIN_W-1:0]   bin,
    input  logic               load,
    output logic               busy,
    output logic               overflow,
    output logic [SEG_W-1:0]   seg,
    output logic [DIGITS-1:0]  an
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int DSEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RC_W   = $clog2(REFRESH_DIV);

    logic              dd_done, dd_over;
    logic [BCD_W-1:0]  dd_bcd;

    logic [BCD_W-1:0]  disp_bcd;
    logic              disp_over;
    logic [RC_W-1:0]   ref_cnt;
    logic [DSEL_W-1:0] digit_sel;

    logic [DSEL_W-1:0] msd;
    logic [3:0]        cur_nib;
    logic              blank;
    logic [SEG_W-1:0]  seg_nx;
    logic [DIGITS-1:0] an_nx;

    bcd_dd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_dd (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .bin   (bin),
        .busy  (busy),
        .done  (dd_done),
        .bcd   (dd_bcd),
        .over  (dd_over)
    );

    // Display register changes only when a conversion finishes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_bcd  <= '0;
            disp_over <= 1'b0;
        end else if (dd_done) begin
            disp_bcd  <= dd_bcd;
            disp_over <= dd_over;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt   <= '0;
            digit_sel <= '0;
        end else if (ref_cnt == RC_W'(REFRESH_DIV - 1)) begin
            ref_cnt   <= '0;
            digit_sel <= (digit_sel == DSEL_W'(DIGITS - 1)) ? '0 : digit_sel + 1'b1;
        end else begin
            ref_cnt   <= ref_cnt + 1'b1;
        end
    end

    always_comb begin
        msd     = '0;
        cur_nib = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (disp_bcd[4*d +: 4] != 4'd0) begin
                msd = DSEL_W'(d);
            end
            if (digit_sel == DSEL_W'(d)) begin
                cur_nib = disp_bcd[4*d +: 4];
            end
        end
        blank = (BLANK_LZ != 0) && (digit_sel > msd) && (digit_sel != '0);

        an_nx = ~(DIGITS'(1) << digit_sel);
        if (disp_over) begin
            seg_nx = SEG_DASH;
        end else if (blank) begin
            seg_nx = SEG_BLANK;
            an_nx  = '1;
        end else begin
            seg_nx = bcd_to_seg(cur_nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_nx;
            an  <= an_nx;
        end
    end

    assign overflow = disp_over;

endmodule
